// File: rtl/lfsr_encrypt_ctrl_if.sv
// Controller-side bundle: start/done handshake, dat_mem ports and LFSR control.
// master = the sequencer, slave = the memory/LFSR/top-level side.
interface lfsr_encrypt_ctrl_if;
   logic       start;
   logic       busy;
   logic       done;
   logic       err;
   logic [7:0] raddr;
   logic [7:0] rdata;
   logic [7:0] waddr;
   logic [7:0] wdata;
   logic       write_en;
   logic       lfsr_en;
   logic       lfsr_load;
   logic [5:0] lfsr_taps;
   logic [5:0] lfsr_start;
   logic [5:0] lfsr_state;

   modport master (
      input  start, rdata, lfsr_state,
      output busy, done, err, raddr, waddr, wdata, write_en,
             lfsr_en, lfsr_load, lfsr_taps, lfsr_start
   );

   modport slave (
      output start, rdata, lfsr_state,
      input  busy, done, err, raddr, waddr, wdata, write_en,
             lfsr_en, lfsr_load, lfsr_taps, lfsr_start
   );
endinterface

// File: rtl/lfsr_encrypt_ctrl.sv
// Sequencer for the LFSR encryption pass: fetch config, write scrambled
// preamble then scrambled message, and report done/err.
module lfsr_encrypt_ctrl #(
   parameter int         MSG_LEN  = 50,
   parameter int         SRC_BASE = 0,
   parameter int         DST_BASE = 64,
   parameter int         CFG_BASE = 61,
   parameter logic [7:0] PAD_CHAR = 8'h5F,
   parameter int         MAX_PRE  = 15
) (
   input  logic                 clk,
   input  logic                 init,
   lfsr_encrypt_ctrl_if.master  bus
);
   localparam logic [7:0] SRC_A    = 8'(SRC_BASE);
   localparam logic [7:0] DST_A    = 8'(DST_BASE);
   localparam logic [7:0] CFG_A    = 8'(CFG_BASE);
   localparam logic [7:0] MAX_P    = 8'(MAX_PRE);
   localparam logic [7:0] MSG_LAST = 8'(MSG_LEN - 1);

   typedef enum logic [2:0] {
      IDLE, RD_PRE, RD_TAPS, RD_START, LOAD, PREAMBLE, MESSAGE, DONE
   } state_t;

   state_t     state, state_nx;
   logic [7:0] pre_len, cnt;
   logic [5:0] taps_q, start_q;
   logic       done_q, err_q;
   logic       bad_cfg, last_pre, last_msg;

   // An all-zero start would lock the LFSR at zero, so it is rejected too.
   assign bad_cfg  = (pre_len > MAX_P) || (start_q == 6'd0);
   assign last_pre = (cnt == pre_len - 8'd1);
   assign last_msg = (cnt == MSG_LAST);

   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         state   <= IDLE;
         pre_len <= '0;
         cnt     <= '0;
         taps_q  <= '0;
         start_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE, DONE: if (bus.start) begin
               done_q <= 1'b0;
               err_q  <= 1'b0;
               cnt    <= '0;
            end
            RD_PRE:   pre_len <= bus.rdata;
            RD_TAPS:  taps_q  <= bus.rdata[5:0];
            RD_START: start_q <= bus.rdata[5:0];
            LOAD: if (bad_cfg) begin
               err_q  <= 1'b1;
               done_q <= 1'b1;
            end
            PREAMBLE: cnt <= last_pre ? 8'd0 : cnt + 8'd1;
            MESSAGE: begin
               if (last_msg) done_q <= 1'b1;
               else          cnt    <= cnt + 8'd1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nx      = state;
      bus.raddr     = '0;
      bus.waddr     = '0;
      bus.wdata     = '0;
      bus.write_en  = 1'b0;
      bus.lfsr_en   = 1'b0;
      bus.lfsr_load = 1'b0;
      case (state)
         IDLE, DONE: if (bus.start) state_nx = RD_PRE;
         RD_PRE: begin
            bus.raddr = CFG_A;
            state_nx  = RD_TAPS;
         end
         RD_TAPS: begin
            bus.raddr = CFG_A + 8'd1;
            state_nx  = RD_START;
         end
         RD_START: begin
            bus.raddr = CFG_A + 8'd2;
            state_nx  = LOAD;
         end
         LOAD: begin
            if (bad_cfg) state_nx = DONE;
            else begin
               bus.lfsr_load = 1'b1;
               state_nx      = (pre_len != 8'd0) ? PREAMBLE : MESSAGE;
            end
         end
         PREAMBLE: begin
            bus.write_en = 1'b1;
            bus.lfsr_en  = 1'b1;
            bus.waddr    = DST_A + cnt;
            bus.wdata    = {2'b00, bus.lfsr_state} ^ PAD_CHAR;
            if (last_pre) state_nx = MESSAGE;
         end
         MESSAGE: begin
            bus.raddr    = SRC_A + cnt;
            bus.write_en = 1'b1;
            bus.lfsr_en  = 1'b1;
            bus.waddr    = DST_A + pre_len + cnt;
            bus.wdata    = bus.rdata ^ {2'b00, bus.lfsr_state};
            if (last_msg) state_nx = DONE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign bus.busy       = (state != IDLE) && (state != DONE);
   assign bus.done       = done_q;
   assign bus.err        = err_q;
   assign bus.lfsr_taps  = taps_q;
   assign bus.lfsr_start = start_q;
endmodule

// File: tb/tb_lfsr_encrypt_ctrl.sv
// Directed bench for lfsr_encrypt_ctrl with a dat_mem and 6-bit LFSR model.
module tb_lfsr_encrypt_ctrl;
   logic clk = 1'b0;
   logic init;
   logic clr_req;
   int   checks = 0;
   int   fails  = 0;

   logic [7:0] src_mem [64];
   logic [7:0] dst_mem [256];
   logic [5:0] lstate = '0;
   logic [5:0] ltaps  = '0;
   int         wcnt   = 0;
   int         lcnt   = 0;
   logic [7:0] last_waddr = '0;

   lfsr_encrypt_ctrl_if bus ();

   lfsr_encrypt_ctrl dut (
      .clk  (clk),
      .init (init),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] lfsr_next(input logic [5:0] s, input logic [5:0] t);
      return {s[4:0], ^(s & t)};
   endfunction

   assign bus.rdata      = (bus.raddr < 8'd64) ? src_mem[bus.raddr[5:0]] : dst_mem[bus.raddr];
   assign bus.lfsr_state = lstate;

   always @(posedge clk) begin
      if (bus.lfsr_load) begin
         lstate <= bus.lfsr_start;
         ltaps  <= bus.lfsr_taps;
      end else if (bus.lfsr_en) begin
         lstate <= lfsr_next(lstate, ltaps);
      end
   end

   always @(posedge clk) begin
      if (clr_req) begin
         for (int i = 0; i < 256; i++) dst_mem[i] <= 8'h00;
      end else if (bus.write_en) begin
         dst_mem[bus.waddr] <= bus.wdata;
         wcnt       <= wcnt + 1;
         last_waddr <= bus.waddr;
      end
      if (bus.lfsr_load) lcnt <= lcnt + 1;
   end

   function automatic logic [63:0] out_vec();
      return {36'd0, bus.busy, bus.done, bus.err, bus.write_en, bus.lfsr_en, bus.lfsr_load,
              bus.lfsr_taps, bus.lfsr_start, bus.raddr} | {32'd0, bus.waddr, bus.wdata, 16'd0};
   endfunction

   task automatic clear_dst();
      @(negedge clk) clr_req = 1'b1;
      @(negedge clk) clr_req = 1'b0;
   endtask

   task automatic set_cfg(input logic [7:0] pre, input logic [7:0] taps, input logic [7:0] st);
      @(negedge clk);
      src_mem[61] = pre;
      src_mem[62] = taps;
      src_mem[63] = st;
   endtask

   task automatic run_pass(input string name, input int exp_lat, input logic exp_err, input int exp_wr);
      int n = 0;
      int w0 = wcnt;
      @(negedge clk) bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
         fails++;
         $display("FAIL %s_accept: busy=%b done=%b, want busy=1 done=0", name, bus.busy, bus.done);
      end
      while (1) begin
         @(posedge clk);
         n++;
         #1;
         if (bus.done === 1'b1 || n >= 400) break;
      end
      checks++;
      if (n !== exp_lat) begin
         fails++;
         $display("FAIL %s_latency: got %0d edges, want %0d", name, n, exp_lat);
      end
      checks++;
      if (bus.err !== exp_err || bus.busy !== 1'b0) begin
         fails++;
         $display("FAIL %s_err: err=%b busy=%b, want err=%b busy=0", name, bus.err, bus.busy, exp_err);
      end
      @(negedge clk);
      checks++;
      if (wcnt - w0 !== exp_wr) begin
         fails++;
         $display("FAIL %s_writes: got %0d, want %0d", name, wcnt - w0, exp_wr);
      end
   endtask

   task automatic check_mem(input string name, input int pre, input logic [5:0] taps, input logic [5:0] st);
      logic [7:0] expv [256];
      logic [5:0] s = st;
      int bad = 0;
      int first = -1;
      for (int i = 0; i < 256; i++) expv[i] = 8'h00;
      for (int k = 0; k < pre; k++) begin
         expv[(64 + k) % 256] = {2'b00, s} ^ 8'h5F;
         s = lfsr_next(s, taps);
      end
      for (int j = 0; j < 50; j++) begin
         expv[(64 + pre + j) % 256] = src_mem[j] ^ {2'b00, s};
         s = lfsr_next(s, taps);
      end
      for (int i = 64; i < 256; i++) begin
         if (dst_mem[i] !== expv[i]) begin
            bad++;
            if (first < 0) first = i;
         end
      end
      checks++;
      if (bad != 0) begin
         fails++;
         $display("FAIL %s_mem: %0d bad bytes, first at %0d got %h want %h",
                  name, bad, first, dst_mem[first], expv[first]);
      end
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if (out_vec() !== 64'd0) begin
         fails++;
         $display("FAIL reset_outputs: got %h, want 0", out_vec());
      end
      @(negedge clk) init = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.write_en !== 1'b0) begin
         fails++;
         $display("FAIL reset_idle: busy=%b done=%b we=%b, want 0/0/0", bus.busy, bus.done, bus.write_en);
      end
   endtask

   task automatic test_basic();
      int l0;
      clear_dst();
      set_cfg(8'd7, 8'h21, 8'h01);
      l0 = lcnt;
      run_pass("basic", 61, 1'b0, 57);
      check_mem("basic", 7, 6'h21, 6'h01);
      checks++;
      if (dst_mem[64] !== 8'h5E || dst_mem[65] !== 8'h5C) begin
         fails++;
         $display("FAIL basic_first_bytes: got %h %h, want 5e 5c", dst_mem[64], dst_mem[65]);
      end
      checks++;
      if (lcnt - l0 !== 1) begin
         fails++;
         $display("FAIL basic_loads: got %0d, want 1", lcnt - l0);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (bus.done !== 1'b1 || bus.lfsr_taps !== 6'h21 || bus.lfsr_start !== 6'h01) begin
         fails++;
         $display("FAIL basic_hold: done=%b taps=%h start=%h, want 1 21 01",
                  bus.done, bus.lfsr_taps, bus.lfsr_start);
      end
   endtask

   task automatic test_pre_zero();
      clear_dst();
      set_cfg(8'd0, 8'h21, 8'h3F);
      run_pass("pre_zero", 54, 1'b0, 50);
      check_mem("pre_zero", 0, 6'h21, 6'h3F);
      checks++;
      if (dst_mem[64] !== 8'h6B) begin
         fails++;
         $display("FAIL pre_zero_first: got %h, want 6b", dst_mem[64]);
      end
   endtask

   task automatic test_bad_config();
      int l0 = lcnt;
      set_cfg(8'd16, 8'h21, 8'h01);
      run_pass("bad_pre", 4, 1'b1, 0);
      set_cfg(8'd7, 8'h21, 8'h00);
      run_pass("bad_start", 4, 1'b1, 0);
      checks++;
      if (lcnt - l0 !== 0) begin
         fails++;
         $display("FAIL bad_loads: got %0d, want 0", lcnt - l0);
      end
   endtask

   task automatic test_reset_mid();
      int w0;
      clear_dst();
      set_cfg(8'd7, 8'h21, 8'h01);
      w0 = wcnt;
      @(negedge clk) bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (31) @(posedge clk);
      #2;
      checks++;
      if (bus.write_en !== 1'b1 || bus.waddr !== 8'd91) begin
         fails++;
         $display("FAIL mid_position: we=%b waddr=%0d, want 1 91", bus.write_en, bus.waddr);
      end
      init = 1'b1;
      #1;
      checks++;
      if (out_vec() !== 64'd0) begin
         fails++;
         $display("FAIL mid_reset_outputs: got %h, want 0", out_vec());
      end
      repeat (3) @(negedge clk);
      checks++;
      if (wcnt - w0 !== 27) begin
         fails++;
         $display("FAIL mid_partial_writes: got %0d, want 27", wcnt - w0);
      end
      init = 1'b0;
      clear_dst();
      run_pass("after_reset", 61, 1'b0, 57);
      check_mem("after_reset", 7, 6'h21, 6'h01);
   endtask

   task automatic test_max_pre();
      clear_dst();
      set_cfg(8'd15, 8'h21, 8'h01);
      run_pass("max_pre", 69, 1'b0, 65);
      checks++;
      if (last_waddr !== 8'd128) begin
         fails++;
         $display("FAIL max_pre_last_waddr: got %0d, want 128", last_waddr);
      end
      check_mem("max_pre", 15, 6'h21, 6'h01);
   endtask

   task automatic test_back_to_back();
      logic [7:0] img [256];
      int n;
      int w0;
      int bad = 0;
      clear_dst();
      set_cfg(8'd7, 8'h21, 8'h01);
      w0 = wcnt;
      @(negedge clk) bus.start = 1'b1;
      @(posedge clk);
      n = 0;
      while (1) begin
         @(posedge clk);
         n++;
         #1;
         if (bus.done === 1'b1 || n >= 400) break;
      end
      checks++;
      if (n !== 61) begin
         fails++;
         $display("FAIL b2b_first_latency: got %0d, want 61", n);
      end
      img = dst_mem;
      clr_req = 1'b1;
      @(posedge clk);
      #1 clr_req = 1'b0;
      checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
         fails++;
         $display("FAIL b2b_reaccept: busy=%b done=%b, want 1 0", bus.busy, bus.done);
      end
      n = 0;
      while (1) begin
         @(posedge clk);
         n++;
         #1;
         if (bus.done === 1'b1 || n >= 400) break;
      end
      bus.start = 1'b0;
      checks++;
      if (n !== 61) begin
         fails++;
         $display("FAIL b2b_second_latency: got %0d, want 61", n);
      end
      @(negedge clk);
      for (int i = 64; i < 256; i++) if (dst_mem[i] !== img[i]) bad++;
      checks++;
      if (bad != 0 || wcnt - w0 !== 114) begin
         fails++;
         $display("FAIL b2b_images: %0d differing bytes, writes %0d, want 0 and 114", bad, wcnt - w0);
      end
      check_mem("b2b", 7, 6'h21, 6'h01);
   endtask

   initial begin
      string msg = "The quick brown fox jumps over the lazy dog 012345";
      init      = 1'b1;
      clr_req   = 1'b0;
      bus.start = 1'b0;
      for (int i = 0; i < 64; i++) src_mem[i] = 8'h00;
      for (int i = 0; i < 50; i++) src_mem[i] = msg[i];
      test_reset();
      test_basic();
      test_pre_zero();
      test_bad_config();
      test_reset_mid();
      test_max_pre();
      test_back_to_back();
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule

// File: doc/lfsr_encrypt_ctrl.md
Name: lfsr_encrypt_ctrl

Overview:
- FSM sequencer that replaces the program-counter decode in the Lab 4 encryption top level.
- It owns the data memory read/write ports and the 6-bit LFSR core's control inputs (en/init/taps/start).
- It fetches pre_len, taps and start from dat_mem[61:63], then writes the LFSR-scrambled "_" preamble and the scrambled message to dat_mem[64...].
- It gives a start/done handshake so the top level and testbench need no cycle counting.

Parameters:
- MSG_LEN, 50: message bytes read from SRC_BASE.
- SRC_BASE, 0: first plaintext address.
- DST_BASE, 64: first ciphertext address.
- CFG_BASE, 61: address of pre_len; taps at CFG_BASE+1, start at CFG_BASE+2.
- PAD_CHAR, 8'h5F: preamble character.
- MAX_PRE, 15: largest legal pre_len.

Ports:
- clk  input  1  system clock
- init  input  1  asynchronous active-high reset
- start  input  1  begin one encryption pass (sampled in IDLE/DONE)
- busy  output  1  pass in progress
- done  output  1  pass finished; held until next accepted start
- err  output  1  config rejected; valid while done=1
- raddr  output  8  dat_mem read address
- rdata  input  8  dat_mem data_out (combinational read of raddr)
- waddr  output  8  dat_mem write address
- wdata  output  8  dat_mem data_in
- write_en  output  1  dat_mem write enable
- lfsr_en  output  1  advance LFSR
- lfsr_load  output  1  load taps/start into LFSR (state valid next cycle)
- lfsr_taps  output  6  captured taps
- lfsr_start  output  6  captured start
- lfsr_state  input  6  LFSR current state

Behaviour:
- Reset (init=1, async):
  - state=IDLE.
  - busy=done=err=0; write_en=lfsr_en=lfsr_load=0.
  - raddr=waddr=wdata=0; lfsr_taps=lfsr_start=0; internal pre_len and counters=0.
- States: IDLE, RD_PRE, RD_TAPS, RD_START, LOAD, PREAMBLE, MESSAGE, DONE.
  - busy=1 in every state except IDLE and DONE.
- IDLE/DONE + start=1: at that edge clear done/err and counters, then go to RD_PRE. start is ignored while busy.
- RD_PRE: raddr=CFG_BASE; pre_len<=rdata at the edge; go to RD_TAPS.
- RD_TAPS: raddr=CFG_BASE+1; lfsr_taps<=rdata[5:0]; go to RD_START.
- RD_START: raddr=CFG_BASE+2; lfsr_start<=rdata[5:0]; go to LOAD.
- LOAD:
  - If pre_len>MAX_PRE or lfsr_start==0: err<=1, done<=1, go to DONE. No lfsr_load, no memory writes.
  - Otherwise: lfsr_load=1 for this cycle. Go to PREAMBLE if pre_len!=0, else MESSAGE.
- PREAMBLE, cycle k=0..pre_len-1:
  - write_en=1, waddr=DST_BASE+k, wdata={2'b00,lfsr_state}^PAD_CHAR, lfsr_en=1.
  - After k=pre_len-1, go to MESSAGE.
- MESSAGE, cycle j=0..MSG_LEN-1:
  - raddr=SRC_BASE+j, write_en=1, waddr=DST_BASE+pre_len+j, wdata=rdata^{2'b00,lfsr_state}, lfsr_en=1.
  - After j=MSG_LEN-1, done<=1 and go to DONE.
- LFSR timing: exactly one advance per written byte. The first write uses the start value itself.
- Latency: from the start-accept edge E0, done rises at edge E0+4+pre_len+MSG_LEN. Total writes = pre_len+MSG_LEN.
- Address arithmetic is 8-bit modulo 256. With defaults the maximum waddr is 64+15+49=128.
- Outside PREAMBLE/MESSAGE: write_en=lfsr_en=0 and waddr/wdata hold 0.
- DONE holds done (and err if set) and the captured taps/start until start or init.
- init mid-pass: immediate return to IDLE with all outputs at reset values. A partial ciphertext may remain in memory; no further writes occur.
- start and init high together: init wins.

Test Plan:
- Basic pass: mem[61]=7, mem[62]=6'h21, mem[63]=6'h01, mem[0..49] = ASCII message, pulse start.
  -> done at E0+61, err=0.
  -> mem[64..70] = {00,LFSR_k}^0x5F and mem[71..120] = msg^LFSR_{7+j}, matching the golden software model.
  -> exactly 57 write_en cycles.
- pre_len=0: mem[61]=0, start=6'h3F.
  -> no preamble; first write to waddr 64 = mem[0]^8'h3F; done at E0+54.
- Bad config: pre_len=16 -> done=1, err=1 at E0+4, zero writes. Repeat with start=0: same response.
- Reset mid-pass: assert init asynchronously during MESSAGE j=20.
  -> outputs zero within the same cycle, state IDLE.
  -> a later start runs a full correct pass.
- Back-to-back: start held high continuously.
  -> second pass accepted on the edge after done rises.
  -> start is ignored while busy; both passes give identical memory images.
- Max preamble: pre_len=15 -> last write waddr=128; done at E0+69.
